seq_subtractor: RTL and testbench

SEQ_SUBTRACTOR -- requirements
Module: seq_subtractor

---
 rtl/seq_subtractor.sv | 149 ++++++++++++++
 tb/tb_seq_subtractor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_subtractor.sv
// Bit-serial subtractor: captures a, b and borrow-in, then resolves one
// difference bit per clock (LSB first) and presents d/bout with a
// valid/ready handshake. The result registers only change when a new
// difference is complete, so d/bout are stable between results.
module seq_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         busy
);

  // Counter must be able to represent N-1; sized as ceil(log2(N+1)).
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [N-1:0]  a_sh_r;
  logic [N-1:0]  b_sh_r;
  logic          br_r;
  logic [CW-1:0] cnt_r;
  logic [N-1:0]  res_r;
  logic [N-1:0]  d_r;
  logic          bout_r;

  logic          a_bit_s;
  logic          b_bit_s;
  logic          diff_s;
  logic          br_nxt_s;
  logic [N-1:0]  res_nxt_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; operands are only looked at in IDLE, out_ready only in DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == LAST_BIT) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // One full-subtractor bit slice; the new diff bit enters the result at the MSB.
  always_comb begin
    a_bit_s   = a_sh_r[0];
    b_bit_s   = b_sh_r[0];
    diff_s    = a_bit_s ^ b_bit_s ^ br_r;
    br_nxt_s  = (~a_bit_s & b_bit_s) | (~(a_bit_s ^ b_bit_s) & br_r);
    res_nxt_s = res_r >> 1'b1;
    res_nxt_s[N-1] = diff_s;
  end

  // Operand capture, bit-serial datapath and result latching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r <= '0;
      b_sh_r <= '0;
      br_r   <= 1'b0;
      cnt_r  <= '0;
      res_r  <= '0;
      d_r    <= '0;
      bout_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sh_r <= a;
            b_sh_r <= b;
            br_r   <= bin;
            cnt_r  <= '0;
            res_r  <= '0;
          end
        end
        RUN: begin
          a_sh_r <= a_sh_r >> 1'b1;
          b_sh_r <= b_sh_r >> 1'b1;
          br_r   <= br_nxt_s;
          res_r  <= res_nxt_s;
          if (cnt_r == LAST_BIT) begin
            // Final bit: publish the completed difference and borrow.
            d_r    <= res_nxt_s;
            bout_r <= br_nxt_s;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DONE: begin
          // Hold everything while the result waits to be consumed.
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs are straight decodes of the state register.
  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == RUN);
  assign out_valid = (state_r == DONE);
  assign d         = d_r;
  assign bout      = bout_r;

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed and randomised self-checking bench for seq_subtractor (N=8).
module tb_seq_subtractor;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       bout;
  logic       busy;

  int tests;
  int fails;

  seq_subtractor #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation, wait (bounded) for the result, then consume it.
  // lat is the number of edges after the accepting edge until out_valid.
  task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic op_bin, output logic [7:0] rd,
                        output logic rbout, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    a = op_a; b = op_b; bin = op_bin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = d;
    rbout = bout;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; bin = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 ||
        d !== 8'h00 || bout !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got ov=%b busy=%b ir=%b d=%h bout=%b, want 0 0 1 00 0",
               out_valid, busy, in_ready, d, bout);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vc [5];
    logic [8:0] ve [5];
    logic [7:0] rd;
    logic       rbout;
    int         lat;
    va[0] = 8'h05; vb[0] = 8'h03; vc[0] = 1'b0; ve[0] = 9'h002;
    va[1] = 8'h03; vb[1] = 8'h05; vc[1] = 1'b0; ve[1] = 9'h1FE;
    va[2] = 8'h00; vb[2] = 8'h00; vc[2] = 1'b1; ve[2] = 9'h1FF;
    va[3] = 8'hFF; vb[3] = 8'hFF; vc[3] = 1'b1; ve[3] = 9'h1FF;
    va[4] = 8'h80; vb[4] = 8'h01; vc[4] = 1'b0; ve[4] = 9'h07F;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vc[i], rd, rbout, lat);
      tests++;
      if ({rbout, rd} !== ve[i]) begin
        fails++;
        $display("FAIL vector%0d: got bout=%b d=%h, want bout=%b d=%h",
                 i, rbout, rd, ve[i][8], ve[i][7:0]);
      end
      tests++;
      if (lat !== 8) begin
        fails++;
        $display("FAIL latency%0d: got %0d edges, want 8", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    a = 8'h5A; b = 8'h3C; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      a = 8'hFF; b = 8'h00; bin = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || d !== 8'h1E || bout !== 1'b0 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL backpressure_hold%0d: got ov=%b d=%h bout=%b ir=%b, want 1 1e 0 0",
                 i, out_valid, d, bout, in_ready);
      end
    end
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_release: got ov=%b ir=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
    tests++;
    if (d !== 8'h1E || bout !== 1'b0) begin
      fails++;
      $display("FAIL result_retained: got d=%h bout=%b, want 1e 0", d, bout);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL no_accept_in_done: got busy=%b ir=%b, want 0 1", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] rd;
    logic       rbout;
    int         lat;
    bit         seen;
    a = 8'h77; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL run_status: got busy=%b ir=%b, want 1 0", busy, in_ready);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || d !== 8'h00 || bout !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_abort: got ov=%b d=%h bout=%b busy=%b ir=%b, want 0 00 0 0 1",
               out_valid, d, bout, busy, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL aborted_no_output: got out_valid pulse=%b, want 0", seen);
    end
    run_op(8'h10, 8'h01, 1'b0, rd, rbout, lat);
    tests++;
    if (rd !== 8'h0F || rbout !== 1'b0 || lat !== 8) begin
      fails++;
      $display("FAIL after_reset_op: got d=%h bout=%b lat=%0d, want 0f 0 8", rd, rbout, lat);
    end
  endtask

  task automatic test_back_to_back();
    int pulse_cyc [3];
    int np;
    int n;
    bit val_ok;
    np = 0;
    val_ok = 1'b1;
    a = 8'h05; b = 8'h03; bin = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 40 && np < 3; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        pulse_cyc[np] = c;
        np++;
        if (d !== 8'h02 || bout !== 1'b0) val_ok = 1'b0;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (np !== 3) begin
      fails++;
      $display("FAIL b2b_pulses: got %0d pulses, want 3", np);
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (pulse_cyc[i] - pulse_cyc[i-1] !== 10) begin
          fails++;
          $display("FAIL b2b_spacing%0d: got %0d cycles, want 10", i,
                   pulse_cyc[i] - pulse_cyc[i-1]);
        end
      end
    end
    tests++;
    if (val_ok !== 1'b1) begin
      fails++;
      $display("FAIL b2b_value: got a wrong d/bout on some pulse, want d=02 bout=0");
    end
    n = 0;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] exp;
    logic [7:0] rd;
    logic       rbout;
    int         lat;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp = {1'b0, ra} - {1'b0, rb} - {8'h00, rc};
      run_op(ra, rb, rc, rd, rbout, lat);
      tests++;
      if ({rbout, rd} !== exp || lat !== 8) begin
        fails++;
        $display("FAIL random%0d: a=%h b=%h bin=%b got bout=%b d=%h lat=%0d, want bout=%b d=%h lat=8",
                 i, ra, rb, rc, rbout, rd, lat, exp[8], exp[7:0]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
